clq_sched: RTL

//  Arbitrates clauses from the CARB unit and the BCP engine into one clause-queue (CLQ) write stream.

---
 rtl/clq_sched_if.sv | 39 +++
 rtl/clq_sched.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/clq_sched_if.sv
// Clause-scheduler bus: the CARB and engine clause inputs with their stalls,
// the CLQ write stream, credit returns, and scheduler status.
//
// Handshake: a source presents a clause with *_valid=1 and holds clause and
// valid stable while the matching sch2*_stall is 1. The clause is taken at
// the first posedge where valid=1 and stall=0. Stall depends only on
// registered state. sch2clq_valid is a one-cycle write strobe with no
// backpressure; clq2sch_credit returns one CLQ entry per cycle it is high.
interface clq_sched_if #(
  parameter int CLA_W       = 16,
  parameter int CLQ_CREDITS = 8
);
  localparam int CRED_W = $clog2(CLQ_CREDITS + 1);

  logic [CLA_W-1:0]  carb2sch;
  logic              carb2sch_valid;
  logic              sch2carb_stall;
  logic [CLA_W-1:0]  eng2sch;
  logic              eng2sch_valid;
  logic              sch2eng_stall;
  logic [CLA_W-1:0]  sch2clq;
  logic              sch2clq_valid;
  logic              clq2sch_credit;
  logic [CRED_W-1:0] sch_credits;
  logic              sch_err;
  logic              arb_state;    // debug: 0 = ENG_PRI, 1 = CARB_TURN

  modport master (
    output carb2sch, carb2sch_valid, eng2sch, eng2sch_valid, clq2sch_credit,
    input  sch2carb_stall, sch2eng_stall, sch2clq, sch2clq_valid,
    input  sch_credits, sch_err, arb_state
  );

  modport slave (
    input  carb2sch, carb2sch_valid, eng2sch, eng2sch_valid, clq2sch_credit,
    output sch2carb_stall, sch2eng_stall, sch2clq, sch2clq_valid,
    output sch_credits, sch_err, arb_state
  );
endinterface

// File: rtl/clq_sched.sv
// Clause-queue scheduler: buffers CARB and engine clauses in per-source FIFOs,
// drains them with an engine-priority arbiter that forces one CARB grant after
// MAX_BURST consecutive engine grants, and issues only while CLQ credits remain.
module clq_sched #(
  parameter int DEPTH       = 4,
  parameter int MAX_BURST   = 4,
  parameter int CLQ_CREDITS = 8,
  parameter int CLA_W       = 16
) (
  input logic        clk,
  input logic        rst,
  clq_sched_if.slave bus
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int CRED_W  = $clog2(CLQ_CREDITS + 1);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int ENG     = 0;
  localparam int CARB    = 1;

  typedef enum logic {ENG_PRI = 1'b0, CARB_TURN = 1'b1} arb_state_t;

  logic [CLA_W-1:0]   mem [2][DEPTH];
  logic [PTR_W-1:0]   wr_ptr [2];
  logic [PTR_W-1:0]   rd_ptr [2];
  logic [CNT_W-1:0]   cnt [2];
  logic [1:0]         full, not_empty, push, pop;
  logic [CLA_W-1:0]   din [2];

  arb_state_t         arb_state, arb_state_nxt;
  logic [BURST_W-1:0] burst_cnt, burst_cnt_nxt;
  logic               grant_eng, grant_carb, issue;
  logic [CLA_W-1:0]   head;
  logic [CRED_W-1:0]  credits;

  // Per-source status; stall comes from the registered count only, so a pop
  // in the same cycle does not open a slot until the next cycle.
  always_comb begin
    din[ENG]  = bus.eng2sch;
    din[CARB] = bus.carb2sch;
    for (int s = 0; s < 2; s++) begin
      full[s]      = (cnt[s] == CNT_W'(DEPTH));
      not_empty[s] = (cnt[s] != '0);
    end
    push[ENG]  = bus.eng2sch_valid  && !full[ENG];
    push[CARB] = bus.carb2sch_valid && !full[CARB];
  end

  assign bus.sch2eng_stall  = full[ENG];
  assign bus.sch2carb_stall = full[CARB];

  // FIFO storage; contents need no reset because the counts gate every read.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) mem[s][wr_ptr[s]] <= din[s];
    end
  end

  // FIFO pointers and counts; pointers wrap naturally at DEPTH (power of 2).
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        cnt[s]    <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
        if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
        if (push[s] && !pop[s])      cnt[s] <= cnt[s] + CNT_W'(1);
        else if (pop[s] && !push[s]) cnt[s] <= cnt[s] - CNT_W'(1);
      end
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      arb_state <= ENG_PRI;
      burst_cnt <= '0;
    end else begin
      arb_state <= arb_state_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Grant selection, issue decision and arbiter next state. CARB_TURN is only
  // entered while CARB holds a clause, which stays there until it is granted.
  always_comb begin
    grant_carb    = not_empty[CARB] && (arb_state == CARB_TURN || !not_empty[ENG]);
    grant_eng     = not_empty[ENG] && !grant_carb;
    issue         = (credits != '0) && (grant_carb || grant_eng);
    pop[CARB]     = issue && grant_carb;
    pop[ENG]      = issue && grant_eng;
    head          = grant_carb ? mem[CARB][rd_ptr[CARB]] : mem[ENG][rd_ptr[ENG]];
    arb_state_nxt = arb_state;
    burst_cnt_nxt = burst_cnt;
    if (issue) begin
      if (grant_carb) begin
        arb_state_nxt = ENG_PRI;
        burst_cnt_nxt = '0;
      end else if (not_empty[CARB]) begin
        burst_cnt_nxt = burst_cnt + BURST_W'(1);
        if (burst_cnt + BURST_W'(1) == BURST_W'(MAX_BURST)) arb_state_nxt = CARB_TURN;
      end else begin
        burst_cnt_nxt = '0;
      end
    end
  end

  // Registered CLQ write port; the clause holds its last value when idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.sch2clq       <= '0;
      bus.sch2clq_valid <= 1'b0;
    end else begin
      bus.sch2clq_valid <= issue;
      if (issue) bus.sch2clq <= head;
    end
  end

  // Credit counter: issue consumes, a returned credit refills; a return with
  // the counter already full is dropped and flagged stickily.
  always_ff @(posedge clk) begin
    if (!rst) begin
      credits     <= CRED_W'(CLQ_CREDITS);
      bus.sch_err <= 1'b0;
    end else begin
      case ({issue, bus.clq2sch_credit})
        2'b10:   credits <= credits - CRED_W'(1);
        2'b01: begin
          if (credits == CRED_W'(CLQ_CREDITS)) bus.sch_err <= 1'b1;
          else                                 credits <= credits + CRED_W'(1);
        end
        default: credits <= credits;
      endcase
    end
  end

  assign bus.sch_credits = credits;
  assign bus.arb_state   = arb_state;
endmodule
